// File: rtl/sobel_pkg.sv
// Types and constants shared by the Sobel frame controller and the datapath beside it.
package sobel_pkg;

    localparam int SOBEL_PIPE_DEPTH = 31;
    localparam int SOBEL_IN_W       = 128;
    localparam int SOBEL_OUT_W      = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } sobel_state_e;

endpackage : sobel_pkg

// File: rtl/sobel_ctrl.sv
// Frame controller for the Sobel datapath: issues input beats, then PIPE_DEPTH zero flush beats,
// and forwards results with backpressure. Define SOBEL_CTRL_PERF_EN to add the output stall counter.
module sobel_ctrl
    import sobel_pkg::*;
#(
    parameter int PIPE_DEPTH = SOBEL_PIPE_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    input  logic [CNT_W-1:0]       frame_beats,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    input  logic [SOBEL_IN_W-1:0]  in_data,
    output logic                   in_ready,
    output logic                   unit_valid_in,
    output logic [SOBEL_IN_W-1:0]  unit_data_in,
    input  logic [SOBEL_OUT_W-1:0] unit_data_out,
    output logic                   out_valid,
    output logic [SOBEL_OUT_W-1:0] out_data,
    output logic                   out_last,
    input  logic                   out_ready
`ifdef SOBEL_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles
`endif
);

    localparam logic [CNT_W:0]   LP_DEPTH     = (CNT_W+1)'(PIPE_DEPTH);
    localparam logic [CNT_W:0]   LP_ISSUE_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] LP_BEAT_ONE  = CNT_W'(1);

    sobel_state_e            r_state;
    sobel_state_e            w_state_nxt;
    logic [CNT_W-1:0]        r_frame_beats;
    logic [CNT_W:0]          r_issue_cnt;
    logic [CNT_W-1:0]        r_out_cnt;
    logic                    r_out_valid;

    logic                    w_fire;
    logic                    w_out_free;
    logic                    w_out_hs;
    logic                    w_out_last;
    logic                    w_start_ok;
    logic                    w_last_issue;
    logic                    w_flush_left;
    logic                    w_emit;
    logic [CNT_W:0]          w_total_issue;
    logic [SOBEL_IN_W-1:0]   w_unit_data;

    // A new beat may only be issued when the result register is empty or draining this cycle,
    // which is what keeps out_data stable under backpressure.
    assign w_out_free    = !r_out_valid || out_ready;
    assign w_out_hs      = r_out_valid && out_ready;
    assign w_out_last    = r_out_valid && (r_out_cnt == r_frame_beats - LP_BEAT_ONE);
    assign w_start_ok    = start && (r_state == IDLE);
    assign w_total_issue = {1'b0, r_frame_beats} + LP_DEPTH;
    assign w_last_issue  = (r_issue_cnt == {1'b0, r_frame_beats} - LP_ISSUE_ONE);
    assign w_flush_left  = (r_issue_cnt < w_total_issue);
    assign w_emit        = w_fire && (r_issue_cnt >= LP_DEPTH);

    // NOTE: every output of this block gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_unit_data = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (frame_beats == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                w_fire      = in_valid && w_out_free;
                w_unit_data = in_data;
                if (w_fire && w_last_issue) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_fire = w_out_free && w_flush_left;
                if (w_out_hs && w_out_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state       <= IDLE;
            r_frame_beats <= '0;
            r_issue_cnt   <= '0;
            r_out_cnt     <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_frame_beats <= frame_beats;
                r_issue_cnt   <= '0;
                r_out_cnt     <= '0;
            end else begin
                if (w_fire) begin
                    r_issue_cnt <= r_issue_cnt + LP_ISSUE_ONE;
                end
                if (w_out_hs) begin
                    r_out_cnt <= r_out_cnt + LP_BEAT_ONE;
                end
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign in_ready      = (r_state == STREAM) && w_out_free;
    assign unit_valid_in = w_fire;
    assign unit_data_in  = w_unit_data;
    assign out_valid     = r_out_valid;
    assign out_data      = unit_data_out;
    assign out_last      = w_out_last;

`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = busy && r_out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_perf_stall <= '0;
        end else if (w_start_ok) begin
            r_perf_stall <= '0;
        end else if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule : sobel_ctrl

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 31, meaning beats from issue of a beat to its result appearing on unit_data_out.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the frame beat counters.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame-start pulse.
REQ-006 SHALL have port frame_beats  input  CNT_W  number of 128-bit input beats in the frame, sampled on start.
REQ-007 SHALL have port busy  output  1  high from an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port in_valid, in_data  input  1/128  input pixel stream (16 x 8-bit).
REQ-010 SHALL have port in_ready  output  1  input accept.
REQ-011 SHALL have port unit_valid_in  output  1  beat-advance strobe to the Sobel datapath.
REQ-012 SHALL have port unit_data_in  output  128  datapath input beat.
REQ-013 SHALL have port unit_data_out  input  512  datapath result beat.
REQ-014 SHALL have port out_valid, out_data, out_last  output  1/512/1  result stream, with out_last marking the final beat.
REQ-015 SHALL have port out_ready  input  1  result accept.

Function
REQ-016 SHALL implement states IDLE, STREAM, FLUSH, DONE.
- IDLE->STREAM on start with frame_beats!=0.
- IDLE->DONE on start with frame_beats==0.
REQ-017 SHALL, in STREAM, define fire = in_valid && (!out_valid || out_ready), and define in_ready = (state==STREAM) && (!out_valid || out_ready).
REQ-018 SHALL, in FLUSH, define fire = (!out_valid || out_ready) and drive unit_data_in = 128'h0; in STREAM, unit_data_in = in_data.
REQ-019 SHALL drive unit_valid_in = fire (combinational); it is never asserted in IDLE or DONE.
REQ-020 SHALL keep a CNT_W+1-bit issue counter (cleared on start, +1 per fire) and go STREAM->FLUSH on the fire that issues beat frame_beats-1.
REQ-021 SHALL issue exactly PIPE_DEPTH flush beats in FLUSH, so total issued per frame = frame_beats+PIPE_DEPTH.
REQ-022 SHALL set out_valid on the edge of a fire whose issue index is >= PIPE_DEPTH; otherwise it clears on out_valid&&out_ready.
REQ-023 SHALL drive out_data = unit_data_out directly; it is stable while out_valid&&!out_ready because no fire occurs then.
REQ-024 SHALL count output handshakes and assert out_last with out_valid on output beat frame_beats-1.
REQ-025 SHALL go FLUSH->DONE on the out_last handshake; DONE lasts one cycle, pulses done, then returns to IDLE.
REQ-026 SHALL ignore start when busy, with no effect on counters or frame_beats.
REQ-027 SHALL set busy = (state!=IDLE).

Reset
REQ-028 SHALL, while rst_b==0, force on the next edge: state IDLE, counters 0, out_valid 0, out_last 0, done 0, busy 0, in_ready 0, unit_valid_in 0.
REQ-029 SHALL abandon any frame in progress on reset mid-frame, emit no done, and accept a new start on the first cycle after rst_b returns high.

Configuration
REQ-030 SHALL, with SOBEL_CTRL_PERF_EN defined, add output perf_stall_cycles [31:0]:
- increments each busy cycle with out_valid&&!out_ready, saturating at 32'hFFFF_FFFF;
- clears on reset and on an accepted start.
REQ-031 SHALL, with SOBEL_CTRL_PERF_EN undefined, have no perf_stall_cycles port and no counter logic.

Structure
REQ-032 SHALL take the state enum typedef, the PIPE_DEPTH default and beat widths (128 in, 512 out) from shared package sobel_pkg.
REQ-033 SHALL contain no sub-module; the parent instantiates sobel_ctrl beside the datapath and connects unit_valid_in/unit_data_in/unit_data_out.

Verification
REQ-034 SHALL cover: frame_beats=4, in_valid=1, out_ready=1 -> 35 unit_valid_in pulses, 4 out beats on fires 31..34, out_last on 4th, done 1 cycle after.
REQ-035 SHALL cover: out_ready=0 while out_valid=1 for 10 cycles -> unit_valid_in=0, in_ready=0, out_data unchanged.
REQ-036 SHALL cover: in_valid toggling every other cycle in STREAM -> fires only on in_valid cycles; flush beats carry zero data.
REQ-037 SHALL cover: start with frame_beats=0 -> no fires, done pulses 1 cycle later, busy high for exactly 1 cycle.
REQ-038 SHALL cover: rst_b low for 1 cycle mid-FLUSH -> all outputs 0 next cycle, no done; a new start then completes normally.
REQ-039 SHALL cover: start pulsed during STREAM with frame_beats=7 -> ignored; the original frame's count is preserved.
